// File: rtl/snn_pkg.sv
`default_nettype none
// ============================================================================
// Module  : snn_pkg
// Brief   : Shared FSM encoding, leak-mode constants and saturation helper.
// Revision: 1.0
// ============================================================================
package snn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic LEAK_SUB   = 1'b0;
  localparam logic LEAK_SHIFT = 1'b1;

  // Clamp a signed value into the unsigned range [0, 2^width-1] (width <= 31).
  function automatic logic [31:0] sat_clamp(input logic signed [31:0] x,
                                            input int unsigned       width);
    logic [31:0] max_u;
    max_u = (32'd1 << width) - 32'd1;
    if (x < 0)
      return 32'd0;
    else if ($unsigned(x) > max_u)
      return max_u;
    else
      return $unsigned(x);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spike_history_buffer.sv
`default_nettype none
// ============================================================================
// Module  : spike_history_buffer
// Brief   : Per-channel spike shift register; tap 0 holds the newest step.
// Revision: 1.0
// ============================================================================
module spike_history_buffer #(
  parameter int N_IN  = 24,
  parameter int DBITS = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          shift,
  input  logic [N_IN-1:0]               spikes_in,
  output logic [N_IN*(2**DBITS)-1:0]    taps
);

  localparam int DEPTH = 2**DBITS;

  for (genvar i = 0; i < N_IN; i++) begin : g_chan
    logic [DEPTH-1:0] r_hist;

    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        r_hist <= '0;
      else if (shift)
        r_hist <= {r_hist[DEPTH-2:0], spikes_in[i]};
    end

    assign taps[i*DEPTH +: DEPTH] = r_hist;
  end

endmodule
`default_nettype wire

// File: rtl/snn_tdm_lif_layer.sv
`default_nettype none
// ============================================================================
// Module  : snn_tdm_lif_layer
// Brief   : Time-multiplexed LIF layer, one neuron per clock, delayed synapses.
// Revision: 1.0
// ============================================================================
module snn_tdm_lif_layer
  import snn_pkg::*;
#(
  parameter int N_IN  = 24,
  parameter int N_OUT = 8,
  parameter int NBITS = 4,
  parameter int VBITS = 8,
  parameter int DBITS = 4,
  parameter int RBITS = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          step,
  input  logic [N_IN-1:0]               input_spikes,
  input  logic [N_IN*N_OUT*NBITS-1:0]   weights,
  input  logic [N_IN*N_OUT*DBITS-1:0]   delays,
  input  logic [VBITS-1:0]              threshold,
  input  logic [VBITS-1:0]              decay,
  input  logic                          leak_mode,
  input  logic [RBITS-1:0]              refractory_period,
  output logic                          busy,
  output logic                          done,
  output logic                          step_dropped,
  output logic [N_OUT-1:0]              output_spikes,
  output logic [N_OUT*VBITS-1:0]        membrane_potential_out
);

  localparam int DEPTH = 2**DBITS;
  localparam int IW    = VBITS + $clog2(N_IN) + 1;
  localparam int IDXW  = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  state_t                   r_state, w_state_next;
  logic [IDXW-1:0]          r_idx;
  logic [VBITS-1:0]         r_v    [N_OUT];
  logic [RBITS-1:0]         r_refr [N_OUT];
  logic [N_OUT-1:0]         r_scratch, w_scratch_next;
  logic                     r_step_dropped;
  logic                     w_accept, w_last, w_spike;
  logic [N_IN*DEPTH-1:0]    w_taps;
  logic signed [IW-1:0]     w_current;
  logic signed [IW:0]       w_sum;
  logic [VBITS-1:0]         w_v_cur, w_leak, w_v_new, w_v_upd;
  logic [RBITS-1:0]         w_refr_cur, w_refr_upd;

  assign w_accept     = (r_state == ST_IDLE) && step && enable;
  assign w_last       = (r_idx == IDXW'(N_OUT-1));
  assign step_dropped = r_step_dropped;

  spike_history_buffer #(
    .N_IN  (N_IN),
    .DBITS (DBITS)
  ) u_hist (
    .clk       (clk),
    .reset     (reset),
    .shift     (w_accept),
    .spikes_in (input_spikes),
    .taps      (w_taps)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_next = ST_UPDATE;
      ST_UPDATE: begin
        busy = 1'b1;
        if (w_last) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Shared neuron datapath for neuron r_idx.
  always_comb begin
    w_current = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (w_taps[i*DEPTH + int'(delays[(int'(r_idx)*N_IN + i)*DBITS +: DBITS])])
        w_current = w_current + IW'(signed'(weights[(int'(r_idx)*N_IN + i)*NBITS +: NBITS]));
    end

    w_v_cur    = r_v[r_idx];
    w_refr_cur = r_refr[r_idx];

    if (leak_mode == LEAK_SHIFT)
      w_leak = w_v_cur - (w_v_cur >> decay[2:0]);
    else
      w_leak = (w_v_cur > decay) ? (w_v_cur - decay) : '0;

    w_sum   = signed'({{(IW+1-VBITS){1'b0}}, w_leak}) + {w_current[IW-1], w_current};
    w_v_new = VBITS'(sat_clamp({{(31-IW){w_sum[IW]}}, w_sum}, VBITS));

    if (w_refr_cur != '0) begin
      w_spike    = 1'b0;
      w_v_upd    = '0;
      w_refr_upd = w_refr_cur - RBITS'(1);
    end else if (w_v_new >= threshold) begin
      w_spike    = 1'b1;
      w_v_upd    = '0;
      w_refr_upd = refractory_period;
    end else begin
      w_spike    = 1'b0;
      w_v_upd    = w_v_new;
      w_refr_upd = '0;
    end

    w_scratch_next        = r_scratch;
    w_scratch_next[r_idx] = w_spike;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx          <= '0;
      r_scratch      <= '0;
      r_step_dropped <= 1'b0;
      output_spikes  <= '0;
      for (int j = 0; j < N_OUT; j++) begin
        r_v[j]    <= '0;
        r_refr[j] <= '0;
      end
    end else begin
      r_step_dropped <= step && busy;
      if (w_accept) begin
        r_idx     <= '0;
        r_scratch <= '0;
      end else if (r_state == ST_UPDATE) begin
        r_v[r_idx]    <= w_v_upd;
        r_refr[r_idx] <= w_refr_upd;
        r_scratch     <= w_scratch_next;
        r_idx         <= r_idx + IDXW'(1);
        // Publish together with the last neuron so spikes are valid while done is high.
        if (w_last) output_spikes <= w_scratch_next;
      end
    end
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_vout
    assign membrane_potential_out[j*VBITS +: VBITS] = r_v[j];
  end

endmodule
`default_nettype wire

// File: tb/tb_snn_tdm_lif_layer.sv
`default_nettype none
// ============================================================================
// Module  : tb_snn_tdm_lif_layer
// Brief   : Directed self-checking bench for snn_tdm_lif_layer.
// Revision: 1.0
// ============================================================================
module tb_snn_tdm_lif_layer;

  localparam int N_IN = 24, N_OUT = 8, NBITS = 4, VBITS = 8, DBITS = 4, RBITS = 4;

  logic                         clk = 1'b0;
  logic                         reset = 1'b1;
  logic                         enable = 1'b1;
  logic                         step = 1'b0;
  logic [N_IN-1:0]              input_spikes = '0;
  logic [N_IN*N_OUT*NBITS-1:0]  weights = '0;
  logic [N_IN*N_OUT*DBITS-1:0]  delays = '0;
  logic [VBITS-1:0]             threshold = '0;
  logic [VBITS-1:0]             decay = '0;
  logic                         leak_mode = 1'b0;
  logic [RBITS-1:0]             refractory_period = '0;
  logic                         busy, done, step_dropped;
  logic [N_OUT-1:0]             output_spikes;
  logic [N_OUT*VBITS-1:0]       membrane_potential_out;

  int n_tests = 0;
  int n_fail  = 0;
  int lat;

  localparam logic [N_IN-1:0] ALL_ON  = 24'hFFFFFF;
  localparam logic [N_IN-1:0] PAT     = 24'hABCDEF;

  snn_tdm_lif_layer #(
    .N_IN(N_IN), .N_OUT(N_OUT), .NBITS(NBITS), .VBITS(VBITS), .DBITS(DBITS), .RBITS(RBITS)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .enable                 (enable),
    .step                   (step),
    .input_spikes           (input_spikes),
    .weights                (weights),
    .delays                 (delays),
    .threshold              (threshold),
    .decay                  (decay),
    .leak_mode              (leak_mode),
    .refractory_period      (refractory_period),
    .busy                   (busy),
    .done                   (done),
    .step_dropped           (step_dropped),
    .output_spikes          (output_spikes),
    .membrane_potential_out (membrane_potential_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rep_v(input logic [VBITS-1:0] v);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < N_OUT; j++) r[j*VBITS +: VBITS] = v;
    return r;
  endfunction

  task automatic set_cfg(input logic [NBITS-1:0] w, input logic [DBITS-1:0] d);
    for (int k = 0; k < N_IN*N_OUT; k++) begin
      weights[k*NBITS +: NBITS] = w;
      delays[k*DBITS +: DBITS]  = d;
    end
  endtask

  task automatic apply_reset;
    @(negedge clk);
    reset = 1'b1;
    step  = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Returns at the negedge inside the done cycle; lat counts cycles after the sampling edge.
  task automatic run_step(input logic [N_IN-1:0] sp, output int l);
    @(negedge clk);
    input_spikes = sp;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    l = 1;
    while (!done && l < 40) begin
      @(negedge clk);
      l++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset mid-update
    set_cfg(4'd7, 4'd0);
    threshold = 8'd255; decay = 8'd2; leak_mode = 1'b0; refractory_period = 4'd0;
    apply_reset;
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_spikes", {56'd0, output_spikes}, 64'd0);
    @(negedge clk); input_spikes = PAT; step = 1'b1;
    @(negedge clk); step = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("midrst_busy", {63'd0, busy}, 64'd0);
    check_eq("midrst_done", {63'd0, done}, 64'd0);
    check_eq("midrst_pot", membrane_potential_out, 64'd0);
    check_eq("midrst_drop", {63'd0, step_dropped}, 64'd0);
    @(negedge clk); reset = 1'b0;
    run_step(PAT, lat);
    check_eq("postrst_lat", lat, 64'd9);
    check_eq("postrst_pot", membrane_potential_out, rep_v(8'd119));

    // Basic drive: I = 17*7 = 119 >= 100
    threshold = 8'd100;
    apply_reset;
    run_step(PAT, lat);
    check_eq("basic_lat", lat, 64'd9);
    check_eq("basic_spk", {56'd0, output_spikes}, 64'hFF);
    check_eq("basic_pot", membrane_potential_out, 64'd0);

    // enable low in IDLE: step ignored
    enable = 1'b0;
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0;
    check_eq("en0_busy", {63'd0, busy}, 64'd0);
    enable = 1'b1;

    // Refractory 3: fires at steps 0, 4, 8
    refractory_period = 4'd3;
    apply_reset;
    for (int s = 0; s < 9; s++) begin
      run_step(PAT, lat);
      check_eq($sformatf("refr_spk%0d", s), {56'd0, output_spikes}, (s % 4 == 0) ? 64'hFF : 64'h00);
      check_eq($sformatf("refr_pot%0d", s), membrane_potential_out, 64'd0);
    end
    refractory_period = 4'd0;

    // Delay 3
    set_cfg(4'd7, 4'd3);
    threshold = 8'd1; decay = 8'd0;
    apply_reset;
    for (int s = 0; s < 5; s++) begin
      run_step((s == 0) ? ALL_ON : '0, lat);
      check_eq($sformatf("dly3_spk%0d", s), {56'd0, output_spikes}, (s == 3) ? 64'hFF : 64'h00);
    end

    // Maximum delay 15: oldest tap
    set_cfg(4'd7, 4'd15);
    apply_reset;
    for (int s = 0; s < 16; s++) begin
      run_step((s == 0) ? ALL_ON : '0, lat);
      if (s >= 13)
        check_eq($sformatf("dly15_spk%0d", s), {56'd0, output_spikes}, (s == 15) ? 64'hFF : 64'h00);
    end

    // Saturation: 168, then 336 -> 255 which meets threshold 255
    set_cfg(4'd7, 4'd0);
    threshold = 8'd255; decay = 8'd0;
    apply_reset;
    run_step(ALL_ON, lat);
    check_eq("sat_pot0", membrane_potential_out, rep_v(8'd168));
    check_eq("sat_spk0", {56'd0, output_spikes}, 64'h00);
    run_step(ALL_ON, lat);
    check_eq("sat_spk1", {56'd0, output_spikes}, 64'hFF);
    check_eq("sat_pot1", membrane_potential_out, 64'd0);

    // Negative drive floors at 0
    set_cfg(4'h8, 4'd0);
    apply_reset;
    run_step(ALL_ON, lat);
    check_eq("neg_pot", membrane_potential_out, 64'd0);
    check_eq("neg_spk", {56'd0, output_spikes}, 64'h00);

    // Threshold 0 fires with no input
    set_cfg(4'd0, 4'd0);
    threshold = 8'd0;
    apply_reset;
    run_step('0, lat);
    check_eq("thr0_spk", {56'd0, output_spikes}, 64'hFF);

    // Dropped step during update; enable drop mid-update must not abort
    set_cfg(4'd7, 4'd0);
    threshold = 8'd255;
    apply_reset;
    @(negedge clk); input_spikes = ALL_ON; step = 1'b1;
    @(negedge clk);
    check_eq("drop_pre", {63'd0, step_dropped}, 64'd0);
    lat = 1;
    @(negedge clk); step = 1'b0; enable = 1'b0; lat = 2;
    check_eq("drop_pulse", {63'd0, step_dropped}, 64'd1);
    @(negedge clk); lat = 3;
    check_eq("drop_clear", {63'd0, step_dropped}, 64'd0);
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_eq("drop_lat", lat, 64'd9);
    check_eq("drop_pot", membrane_potential_out, rep_v(8'd168));
    enable = 1'b1;

    // Proportional leak: 120 + 80 = 200, then 200 - (200>>1) = 100
    set_cfg(4'd5, 4'd0);
    apply_reset;
    run_step(ALL_ON, lat);
    run_step(24'h00FFFF, lat);
    check_eq("pl_pot200", membrane_potential_out, rep_v(8'd200));
    leak_mode = 1'b1; decay = 8'd1;
    run_step('0, lat);
    check_eq("pl_pot100", membrane_potential_out, rep_v(8'd100));
    leak_mode = 1'b0; decay = 8'd150;
    run_step('0, lat);
    check_eq("sub_floor", membrane_potential_out, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
